// File: rtl/txn_fifo_param.sv
// Parametrised synchronous FIFO buffering APB transactions between the request source and the APB master.
// Supports first-word-fall-through or registered-read output, threshold flags and sticky error flags.
module txn_fifo_param #(
  parameter int DATA_W    = 66,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 1,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              rd_ok;
  logic              wr_ok;

  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AFULL_C);
  assign almost_empty = (count_reg <= AEMPTY_C);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= (overflow_reg && !clr_err) || (wr_en && !wr_ok && !flush);
      underflow_reg <= (underflow_reg && !clr_err) || (rd_en && !rd_ok && !flush);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = empty ? '0 : mem[rd_ptr_reg];
    end else begin : g_reg
      logic [DATA_W-1:0] dout_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_reg <= '0;
        end else if (flush) begin
          dout_reg <= '0;
        end else if (rd_ok) begin
          dout_reg <= mem[rd_ptr_reg];
        end
      end
      assign dout = dout_reg;
    end
  endgenerate

endmodule
